// File: rtl/serial_exec_ctrl_if.sv
// Handshake and control bundle between the bit-serial sequencer and its datapath.
interface serial_exec_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic             inst_valid;
  logic             run_mode;
  logic [3:0]       opcode;
  logic [11:0]      instr;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [2:0]       rs1;
  logic [2:0]       rs2;
  logic [2:0]       reg_waddr;
  logic             reg_read_en;
  logic             reg_shift_en;
  logic             reg_write_en;
  logic             use_imm;
  logic [WIDTH-1:0] imm;
  logic             imm_load;
  logic             imm_shift_en;
  logic             acc_clr;
  logic             acc_shift_en;
  logic [1:0]       alu_op;
  logic             b_invert;
  logic             carry_load;
  logic             carry_init;
  logic             carry_en;
  logic [CNT_W-1:0] bit_idx;
  logic             last_bit;

  modport master (
    output start, inst_valid, run_mode, opcode, instr,
    input  busy, done, illegal, rs1, rs2, reg_waddr, reg_read_en, reg_shift_en,
           reg_write_en, use_imm, imm, imm_load, imm_shift_en, acc_clr,
           acc_shift_en, alu_op, b_invert, carry_load, carry_init, carry_en,
           bit_idx, last_bit
  );

  modport slave (
    input  start, inst_valid, run_mode, opcode, instr,
    output busy, done, illegal, rs1, rs2, reg_waddr, reg_read_en, reg_shift_en,
           reg_write_en, use_imm, imm, imm_load, imm_shift_en, acc_clr,
           acc_shift_en, alu_op, b_invert, carry_load, carry_init, carry_en,
           bit_idx, last_bit
  );
endinterface

// File: rtl/serial_exec_ctrl.sv
// Bit-serial execute sequencer: accept, operand load, WIDTH serial cycles, writeback.
module serial_exec_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic              clk,
  input logic              rstn,
  serial_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       rs1_q, rs1_d;
  logic [7:0]       hi_q, hi_d;     // instr[11:4]; low three bits double as rs2
  logic [CNT_W-1:0] bit_q, bit_d;
  logic             illegal_q, illegal_d;
  logic             is_sub;
  logic [WIDTH-1:0] imm_ext;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0110, 4'b0101, 4'b0100,
      4'b1000, 4'b1001, 4'b1100, 4'b1011, 4'b1010: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  endfunction

  // State and latched instruction fields
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      hi_q      <= '0;
      bit_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      hi_q      <= hi_d;
      bit_q     <= bit_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state: accept/reject, bit counting and run-mode chaining from WB
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    hi_d      = hi_q;
    bit_d     = bit_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.inst_valid) begin
          if (op_legal(bus.opcode)) begin
            op_d    = bus.opcode;
            rs1_d   = bus.instr[2:0];
            hi_d    = bus.instr[11:4];
            state_d = LOAD;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      LOAD: begin
        bit_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (bit_q == LAST) begin
          bit_d   = '0;
          state_d = WB;
        end else begin
          bit_d = bit_q + CNT_W'(1);
        end
      end
      WB: begin
        state_d = IDLE;
        if (bus.run_mode && bus.inst_valid) begin
          if (op_legal(bus.opcode)) begin
            op_d    = bus.opcode;
            rs1_d   = bus.instr[2:0];
            hi_d    = bus.instr[11:4];
            state_d = LOAD;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Immediate extension: only ADDI/SUBI (1000/1001) sign-extend; R-type gives zero
  always_comb begin
    imm_ext = '0;
    if (op_q[3]) begin
      if (op_q[2:1] == 2'b00) imm_ext = {WIDTH{hi_q[7]}};
      imm_ext[7:0] = hi_q;
    end
  end

  // ALU function select from the latched opcode
  always_comb begin
    is_sub = (op_q == 4'b0001) || (op_q == 4'b1001);
    case (op_q)
      4'b0110, 4'b1100: bus.alu_op = 2'b01;
      4'b0101, 4'b1011: bus.alu_op = 2'b10;
      4'b0100, 4'b1010: bus.alu_op = 2'b11;
      default:          bus.alu_op = 2'b00;
    endcase
  end

  // Moore control strobes per state
  always_comb begin
    bus.busy         = (state_q != IDLE);
    bus.done         = 1'b0;
    bus.reg_read_en  = 1'b0;
    bus.reg_shift_en = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.imm_load     = 1'b0;
    bus.imm_shift_en = 1'b0;
    bus.acc_clr      = 1'b0;
    bus.acc_shift_en = 1'b0;
    bus.carry_load   = 1'b0;
    bus.carry_en     = 1'b0;
    bus.last_bit     = 1'b0;
    case (state_q)
      LOAD: begin
        bus.reg_read_en = 1'b1;
        bus.imm_load    = op_q[3];
        bus.acc_clr     = 1'b1;
        bus.carry_load  = 1'b1;
      end
      EXEC: begin
        bus.reg_shift_en = 1'b1;
        bus.imm_shift_en = op_q[3];
        bus.acc_shift_en = 1'b1;
        bus.carry_en     = 1'b1;
        bus.last_bit     = (bit_q == LAST);
      end
      WB: begin
        bus.reg_write_en = 1'b1;
        bus.done         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.illegal    = illegal_q;
  assign bus.rs1        = rs1_q;
  assign bus.reg_waddr  = rs1_q;
  assign bus.rs2        = op_q[3] ? 3'b000 : hi_q[2:0];
  assign bus.use_imm    = op_q[3];
  assign bus.imm        = imm_ext;
  assign bus.b_invert   = is_sub;
  assign bus.carry_init = is_sub;
  assign bus.bit_idx    = bit_q;

endmodule

// File: doc/serial_exec_ctrl.md
Name: serial_exec_ctrl

Overview:
Parametrised control sequencer for the bit-serial datapath. It accepts one instruction per start pulse, or chains instructions back-to-back in run mode. It sequences operand load, WIDTH serial execute cycles and a register-file writeback, and it owns its own bit counter. Compared with the previous controller it adds configurable data width, immediate sign/zero extension, subtract control (operand invert and carry-in), illegal-opcode detection and done/busy handshakes.

Parameters:
WIDTH, 8, serial data width in bits; must be at least 8.
CNT_W, 3, bit counter width; must equal clog2(WIDTH).

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse
inst_valid  input  1  opcode/instr hold a complete instruction
run_mode  input  1  0 = single instruction per start; 1 = chain while inst_valid
opcode  input  4  bit3 = 1 means I-type
instr  input  12  instruction bits 15:4
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse in the WB cycle
illegal  output  1  one-cycle pulse after an illegal opcode is rejected
rs1  output  3  latched instr[2:0]; also the destination
rs2  output  3  latched instr[6:4] for R-type, else 0
reg_waddr  output  3  equals rs1
reg_read_en  output  1  parallel operand fetch
reg_shift_en  output  1  shift operand registers one bit
reg_write_en  output  1  write accumulator into reg_waddr
use_imm  output  1  latched opcode[3]
imm  output  WIDTH  extended immediate, held stable from LOAD until the next accept
imm_load  output  1  load imm into the immediate shifter
imm_shift_en  output  1  shift immediate one bit
acc_clr  output  1  clear accumulator
acc_shift_en  output  1  shift ALU result bit into accumulator
alu_op  output  2  00 add, 01 xor, 10 and, 11 or
b_invert  output  1  invert ALU B operand (SUB/SUBI)
carry_load  output  1  load carry flop with carry_init
carry_init  output  1  1 for SUB/SUBI, else 0
carry_en  output  1  carry flop update enable
bit_idx  output  CNT_W  current serial bit, LSB first
last_bit  output  1  EXEC and bit_idx equals WIDTH-1

Behaviour:
- Reset (asynchronous, rstn low): state IDLE; latched fields 0; bit_idx 0; every output 0, including busy, done, illegal and imm. Reset asserted mid-instruction aborts it with no write.
- States: IDLE, LOAD, EXEC, WB.
- Accept condition: IDLE and start and inst_valid. On accept, opcode/instr are latched and the latched opcode is decoded.
  - Legal opcode: go to LOAD.
  - Illegal opcode: stay in IDLE; illegal pulses on the next cycle; no other output toggles.
- start is ignored when inst_valid is 0 or busy is 1.
- Legal opcodes:
  - 0000 ADD, 0001 SUB, 0110 XOR, 0101 AND, 0100 OR.
  - 1000 ADDI, 1001 SUBI, 1100 XORI, 1011 ANDI, 1010 ORI.
  - All other opcodes are illegal.
- alu_op: ADD/SUB = 00, XOR = 01, AND = 10, OR = 11. b_invert and carry_init are 1 only for SUB/SUBI.
- imm = instr[11:4], extended to WIDTH bits: sign-extended for ADDI/SUBI, zero-extended for XORI/ANDI/ORI, 0 for R-type.
- LOAD (1 cycle): reg_read_en, imm_load (I-type only), acc_clr, carry_load; bit_idx cleared to 0.
- EXEC (WIDTH cycles):
  - Asserted every cycle: reg_shift_en, imm_shift_en (I-type only), acc_shift_en, carry_en, with alu_op, b_invert and use_imm valid.
  - bit_idx increments 0 to WIDTH-1; last_bit is high on the final cycle, then the state moves to WB.
- WB (1 cycle): reg_write_en and done asserted, reg_waddr = rs1.
  - If run_mode and inst_valid: latch the new instruction this cycle and go to LOAD (illegal opcode: illegal pulse, go to IDLE).
  - Otherwise go to IDLE.
- Latency: accept at cycle T; LOAD at T+1; EXEC T+2 through T+1+WIDTH; WB/done at T+2+WIDTH; busy is 0 at T+3+WIDTH in single mode.
- rs1, rs2, use_imm and imm stay stable from LOAD through WB.
- All control outputs are Moore, decoded from state and latched fields. The only mid-cycle input dependence is the run_mode/inst_valid decision in WB.

Test Plan:
- Reset: rstn low mid-EXEC at bit 3 with WIDTH=8 -> all outputs 0 immediately, no reg_write_en; after release, busy = 0.
- ADD R-type, WIDTH=8: opcode 0000, instr 0x021 (rs1=1, rs2=2), start at T -> LOAD at T+1, 8 EXEC cycles, last_bit at T+9, done and reg_write_en at T+10 with reg_waddr=1, alu_op=00, b_invert=0.
- SUBI with WIDTH=16: opcode 1001, instr[11:4]=0xF0 -> imm=0xFFF0, b_invert=1, carry_init=1, carry_load in LOAD, 16 EXEC cycles, done at T+18.
- ANDI zero-extension, WIDTH=16: instr[11:4]=0x80 -> imm=0x0080, alu_op=10.
- Illegal opcode 1111 with start -> illegal pulses 1 cycle later, busy stays 0; a start during busy is ignored and the current instruction completes unchanged.
- run_mode=1, inst_valid held high, two ORs -> WB of the first goes directly to LOAD of the second; two done pulses WIDTH+2 cycles apart; busy never drops between them.
